axi_mem_responder: RTL and testbench

AXI4 memory responder, the slave end of the `axi_inf` link driven by the data and instruction caches. It accepts single-beat and burst reads/writes (cache line fills and evictions) and serves them from an internal byte-addressable RAM. It is used as the backing store in simulation and FPGA bring-up in place of the external memory controller. A backdoor port preloads program/data images.

---
 rtl/axi_mem_responder_if.sv | 57 +++++
 rtl/axi_mem_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// AXI4 link between the caches (master) and the memory responder (slave).
// Both ends must be built with the same ADDR_SIZE / DATA_SIZE / ID_SIZE.
interface axi_inf #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int ID_SIZE   = 4
);
    logic [ID_SIZE-1:0]     arid;
    logic [ADDR_SIZE-1:0]   araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid;
    logic                   arready;

    logic [ID_SIZE-1:0]     rid;
    logic [DATA_SIZE-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    logic [ID_SIZE-1:0]     awid;
    logic [ADDR_SIZE-1:0]   awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;

    logic [DATA_SIZE-1:0]   wdata;
    logic [DATA_SIZE/8-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;

    logic [ID_SIZE-1:0]     bid;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal RAM, with a backdoor preload port.
// Optional macro AXI_MEM_RANDOM_STALL_EN: LFSR-driven stalls on rvalid/wready.
//
// state   | meaning
// R_IDLE  | arready high, waiting for an AR handshake
// R_WAIT  | read latency countdown
// R_BURST | presenting R beats
// W_IDLE  | awready high, waiting for an AW handshake
// W_DATA  | accepting W beats
// W_RESP  | presenting the B response
module axi_mem_responder #(
    parameter int                   ADDR_SIZE  = 32,
    parameter int                   DATA_SIZE  = 32,
    parameter int                   ID_SIZE    = 4,
    parameter int                   MEM_BYTES  = 2**16,
    parameter int                   RD_LATENCY = 2,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = '0
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    axi_inf.slave                axi,
    input  logic                 i_bd_we,
    input  logic [ADDR_SIZE-1:0] i_bd_addr,
    input  logic [DATA_SIZE-1:0] i_bd_wdata,
    output logic                 o_busy
);
    localparam int BPW      = DATA_SIZE / 8;
    localparam int MAX_SIZE = $clog2(BPW);
    localparam int WORDS    = MEM_BYTES / BPW;
    localparam int IDX_W    = $clog2(WORDS);
    localparam logic [ADDR_SIZE-1:0] MEM_LIM = ADDR_SIZE'(MEM_BYTES);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return (a - BASE_ADDR) < MEM_LIM;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_SIZE-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> MAX_SIZE);
    endfunction

    function automatic logic bad_xfer(input logic [2:0] size, input logic [7:0] len,
                                      input logic [1:0] burst);
        return (size > 3'(MAX_SIZE)) ||
               ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a,
                                                       input logic [2:0] size,
                                                       input logic [7:0] len,
                                                       input logic [1:0] burst);
        logic [ADDR_SIZE-1:0] step, mask;
        step = ADDR_SIZE'(1) << size;
        mask = ((ADDR_SIZE'(len) + ADDR_SIZE'(1)) << size) - ADDR_SIZE'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + step) & mask);
            default: return a + step;
        endcase
    endfunction

    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_SIZE-1:0] mem [WORDS];

    rd_state_t            rd_state_q, rd_state_d;
    logic [ID_SIZE-1:0]   rid_q, rid_d;
    logic [ADDR_SIZE-1:0] raddr_q, raddr_d;
    logic [7:0]           rlen_q, rlen_d, rbeat_q, rbeat_d, rcnt_q, rcnt_d;
    logic [2:0]           rsize_q, rsize_d;
    logic [1:0]           rburst_q, rburst_d;
    logic                 rerr_q, rerr_d;

    wr_state_t            wr_state_q, wr_state_d;
    logic [ID_SIZE-1:0]   bid_q, bid_d;
    logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
    logic [7:0]           wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [2:0]           wsize_q, wsize_d;
    logic [1:0]           wburst_q, wburst_d, bresp_q, bresp_d;
    logic                 werr_q, werr_d;

    logic ready_en_q, ready_en_d;
    logic stall, arready_w, rvalid_w, awready_w, wready_w, bvalid_w, mem_we;

`ifdef AXI_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge i_aclk or negedge i_areset_n)
        if (!i_areset_n) lfsr_q <= 16'hACE1;
        else             lfsr_q <= lfsr_d;
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rbeat_d    = rbeat_q;
        rcnt_d     = rcnt_q;
        rerr_d     = rerr_q;
        arready_w  = 1'b0;
        rvalid_w   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                arready_w = ready_en_q;
                if (axi.arvalid && ready_en_q) begin
                    rid_d      = axi.arid;
                    raddr_d    = axi.araddr;
                    rlen_d     = axi.arlen;
                    rsize_d    = axi.arsize;
                    rburst_d   = axi.arburst;
                    rbeat_d    = '0;
                    rcnt_d     = 8'(RD_LATENCY);
                    rerr_d     = bad_xfer(axi.arsize, axi.arlen, axi.arburst);
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rcnt_q == '0) rd_state_d = R_BURST;
                else              rcnt_d = rcnt_q - 8'd1;
            end
            R_BURST: begin
                rvalid_w = !stall;
                if (rvalid_w && axi.rready) begin
                    raddr_d = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
                    rbeat_d = rbeat_q + 8'd1;
                    if (rbeat_q == rlen_q) rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        bid_d      = bid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        wbeat_d    = wbeat_q;
        werr_d     = werr_q;
        bresp_d    = bresp_q;
        awready_w  = 1'b0;
        wready_w   = 1'b0;
        bvalid_w   = 1'b0;
        mem_we     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                awready_w = ready_en_q;
                if (axi.awvalid && ready_en_q) begin
                    bid_d      = axi.awid;
                    waddr_d    = axi.awaddr;
                    wlen_d     = axi.awlen;
                    wsize_d    = axi.awsize;
                    wburst_d   = axi.awburst;
                    wbeat_d    = '0;
                    werr_d     = bad_xfer(axi.awsize, axi.awlen, axi.awburst);
                    bresp_d    = werr_d ? 2'b10 : 2'b00;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready_w = !stall;
                if (wready_w && axi.wvalid) begin
                    mem_we  = !werr_q && in_range(waddr_q);
                    if (!in_range(waddr_q)) bresp_d = worse(bresp_d, 2'b11);
                    waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                    wbeat_d = wbeat_q + 8'd1;
                    // Early or missing wlast still terminates the burst, flagged as SLVERR.
                    if (axi.wlast || (wbeat_q == wlen_q)) begin
                        if (axi.wlast != (wbeat_q == wlen_q)) bresp_d = worse(bresp_d, 2'b10);
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid_w = 1'b1;
                if (axi.bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign ready_en_d = 1'b1;

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            ready_en_q <= 1'b0;
            rd_state_q <= R_IDLE;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rbeat_q    <= '0;
            rcnt_q     <= '0;
            rerr_q     <= 1'b0;
            wr_state_q <= W_IDLE;
            bid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            wbeat_q    <= '0;
            werr_q     <= 1'b0;
            bresp_q    <= 2'b00;
        end else begin
            ready_en_q <= ready_en_d;
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rsize_q    <= rsize_d;
            rburst_q   <= rburst_d;
            rbeat_q    <= rbeat_d;
            rcnt_q     <= rcnt_d;
            rerr_q     <= rerr_d;
            wr_state_q <= wr_state_d;
            bid_q      <= bid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wsize_q    <= wsize_d;
            wburst_q   <= wburst_d;
            wbeat_q    <= wbeat_d;
            werr_q     <= werr_d;
            bresp_q    <= bresp_d;
        end
    end

    // Backdoor is written last so it wins over an AXI write to the same word.
    always_ff @(posedge i_aclk) begin
        if (mem_we)
            for (int i = 0; i < BPW; i++)
                if (axi.wstrb[i]) mem[word_idx(waddr_q)][i*8 +: 8] <= axi.wdata[i*8 +: 8];
        if (i_bd_we && in_range(i_bd_addr))
            mem[word_idx(i_bd_addr)] <= i_bd_wdata;
    end

    assign axi.arready = arready_w;
    assign axi.rvalid  = rvalid_w;
    assign axi.rid     = rid_q;
    assign axi.rlast   = (rd_state_q == R_BURST) && (rbeat_q == rlen_q);
    assign axi.rdata   = ((rd_state_q == R_BURST) && in_range(raddr_q)) ?
                         mem[word_idx(raddr_q)] : '0;
    assign axi.rresp   = (rd_state_q != R_BURST) ? 2'b00 :
                         !in_range(raddr_q)      ? 2'b11 :
                         rerr_q                  ? 2'b10 : 2'b00;
    assign axi.awready = awready_w;
    assign axi.wready  = wready_w;
    assign axi.bvalid  = bvalid_w;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign o_busy      = (rd_state_q != R_IDLE) || (wr_state_q != W_IDLE);
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed scoreboard bench for axi_mem_responder (default parameters, 64 KiB at base 0).
module tb_axi_mem_responder;
    localparam int MEM = 65536;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = '0;
    logic [31:0] bd_wdata = '0;
    logic        busy;

    axi_inf #(.ADDR_SIZE(32), .DATA_SIZE(32), .ID_SIZE(4)) axi ();

    axi_mem_responder #(
        .ADDR_SIZE(32), .DATA_SIZE(32), .ID_SIZE(4), .MEM_BYTES(MEM),
        .RD_LATENCY(2), .BASE_ADDR(32'h0)
    ) dut (
        .i_aclk(clk), .i_areset_n(rst_n), .axi(axi),
        .i_bd_we(bd_we), .i_bd_addr(bd_addr), .i_bd_wdata(bd_wdata), .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    rexp_t       rq[$];
    logic [5:0]  bq[$];
    logic [31:0] mdl [int unsigned];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int checks = 0, errors = 0, rd_hs = 0, wr_hs = 0, lat = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bad(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
        return size > 3'd2 || (burst == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] size,
                                        input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] step, win, base;
        step = 32'd1 << size;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            win  = (32'(len) + 1) * step;
            base = a - (a % win);
            return base + ((a - base + step) % win);
        end
        return a + step;
    endfunction

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        mdl[a >> 2] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int stall_at,
                           output int latency);
        logic [31:0] a;
        rexp_t e;
        int n, beat, held;
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            e.data = (a < MEM) ? mdl[a >> 2] : 32'h0;
            e.resp = (a >= MEM) ? 2'b11 : bad(size, len, burst) ? 2'b10 : 2'b00;
            e.last = (b == int'(len));
            e.id   = id;
            rq.push_back(e);
            a = nxt(a, size, len, burst);
        end
        @(negedge clk);
        axi.arvalid = 1'b1; axi.araddr = addr; axi.arlen = len;
        axi.arsize = size; axi.arburst = burst; axi.arid = id;
        n = 0;
        while (!axi.arready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("ar_timeout", 1, 0);
        @(negedge clk);
        axi.arvalid = 1'b0; axi.rready = 1'b1;
        latency = 0; beat = 0; held = 0; n = 0;
        while (beat <= int'(len) && n < 400) begin
            if (axi.rvalid) begin
                if (beat == stall_at && held < 2) begin
                    axi.rready = 1'b0;
                    chk("r_hold", axi.rdata, rq[0].data);
                    held++;
                end else begin
                    axi.rready = 1'b1;
                    e = rq.pop_front();
                    chk("rdata", axi.rdata, e.data);
                    chk("rresp", axi.rresp, e.resp);
                    chk("rlast", axi.rlast, e.last);
                    chk("rid", axi.rid, e.id);
                    beat++; rd_hs++;
                end
            end else if (beat == 0) latency++;
            @(negedge clk); n++;
        end
        if (beat <= int'(len)) chk("r_timeout", 1, 0);
        axi.rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int nbeats,
                            input logic [1:0] exp_resp);
        logic [31:0] a;
        logic [5:0]  eb;
        int n;
        bq.push_back({id, exp_resp});
        @(negedge clk);
        axi.awvalid = 1'b1; axi.awaddr = addr; axi.awlen = len;
        axi.awsize = size; axi.awburst = burst; axi.awid = id;
        n = 0;
        while (!axi.awready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("aw_timeout", 1, 0);
        @(negedge clk);
        axi.awvalid = 1'b0;
        a = addr;
        for (int b = 0; b < nbeats; b++) begin
            axi.wvalid = 1'b1; axi.wdata = wd[b]; axi.wstrb = ws[b]; axi.wlast = (b == nbeats - 1);
            n = 0;
            while (!axi.wready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) chk("w_timeout", 1, 0);
            if (a < MEM && !bad(size, len, burst))
                for (int i = 0; i < 4; i++)
                    if (ws[b][i]) mdl[a >> 2][i*8 +: 8] = wd[b][i*8 +: 8];
            wr_hs++;
            @(negedge clk);
            a = nxt(a, size, len, burst);
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
        n = 0;
        while (!axi.bvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("b_timeout", 1, 0);
        eb = bq.pop_front();
        chk("bresp", axi.bresp, eb[1:0]);
        chk("bid", axi.bid, eb[5:2]);
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    initial begin
        axi.arvalid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0; axi.arid = 0;
        axi.rready = 0; axi.awvalid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0;
        axi.awburst = 0; axi.awid = 0; axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0;
        axi.wlast = 0; axi.bready = 0;

        // reset state
        @(negedge clk);
        chk("rst_arready", axi.arready, 0);
        chk("rst_awready", axi.awready, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_rlast", axi.rlast, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_resp", {axi.rresp, axi.bresp}, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1 chk("rel_arready_early", axi.arready, 0);
        @(negedge clk);
        chk("rel_arready", axi.arready, 1);
        chk("rel_awready", axi.awready, 1);
        chk("idle_wready", axi.wready, 0);

        // single read latency
        bd_write(32'h1000, 32'hDEADBEEF);
        bd_write(32'h1004, 32'h11111111);
        bd_write(32'h1008, 32'h22222222);
        bd_write(32'h100C, 32'h33333333);
        do_read(32'h1000, 8'd0, 3'd2, 2'b01, 4'd3, -1, lat);
`ifndef AXI_MEM_RANDOM_STALL_EN
        chk("rd_latency", lat, 3);
`endif

        // wrap read with mid-burst stall
        do_read(32'h100C, 8'd3, 3'd2, 2'b10, 4'd5, 2, lat);

        // INCR write with partial strobes
        bd_write(32'h2000, 32'hAABBCCDD);
        bd_write(32'h2004, 32'h00000000);
        wd[0] = 32'h11223344; ws[0] = 4'b0011;
        wd[1] = 32'h55667788; ws[1] = 4'b1111;
        do_write(32'h2000, 8'd1, 3'd2, 2'b01, 4'd6, 2, 2'b00);
        chk("model_strb", mdl[32'h2000 >> 2], 32'hAABB3344);
        do_read(32'h2000, 8'd1, 3'd2, 2'b01, 4'd7, -1, lat);

        // out of range read/write, no aliasing into RAM
        bd_write(32'h0000, 32'h01234567);
        do_read(MEM, 8'd1, 3'd2, 2'b01, 4'd8, -1, lat);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(MEM, 8'd0, 3'd2, 2'b01, 4'd9, 1, 2'b11);
        do_read(32'h0000, 8'd0, 3'd2, 2'b01, 4'd1, -1, lat);

        // oversize write suppressed; early wlast flagged
        bd_write(32'h2008, 32'hCAFEF00D);
        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(32'h2008, 8'd0, 3'd3, 2'b01, 4'd2, 1, 2'b10);
        do_read(32'h2008, 8'd0, 3'd2, 2'b01, 4'd2, -1, lat);
        bd_write(32'h2010, 32'h0);
        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        do_write(32'h2010, 8'd1, 3'd2, 2'b01, 4'd4, 1, 2'b10);
        do_read(32'h2010, 8'd0, 3'd2, 2'b01, 4'd4, -1, lat);

        // concurrent read and write
        for (int i = 0; i < 8; i++) begin
            bd_write(32'h3000 + 32'(4 * i), 32'hA0000000 + 32'(i));
            wd[i] = 32'h5A5A0000 + 32'(i * 17); ws[i] = 4'hF;
        end
        fork
            do_read(32'h3000, 8'd7, 3'd2, 2'b01, 4'd10, -1, lat);
            do_write(32'h4000, 8'd7, 3'd2, 2'b01, 4'd11, 8, 2'b00);
        join
        do_read(32'h4000, 8'd7, 3'd2, 2'b01, 4'd12, -1, lat);

        // reset mid-read
        @(negedge clk);
        axi.arvalid = 1'b1; axi.araddr = 32'h3000; axi.arlen = 8'd7;
        axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arid = 4'd13;
        @(negedge clk);
        axi.arvalid = 1'b0; axi.rready = 1'b1;
        for (int n = 0; n < 50 && !axi.rvalid; n++) @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", axi.rvalid, 0);
        chk("mid_rst_arready", axi.arready, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rel_arready0", axi.arready, 0);
        @(negedge clk);
        chk("post_rel_arready1", axi.arready, 1);
        chk("post_rel_rvalid", axi.rvalid, 0);
        chk("post_rel_bvalid", axi.bvalid, 0);
        axi.rready = 1'b0;

        // 16-beat write then read back, handshake counts
        rd_hs = 0; wr_hs = 0;
        for (int i = 0; i < 16; i++) begin
            wd[i] = 32'hC0DE0000 + 32'(i * 257); ws[i] = 4'hF;
        end
        do_write(32'h5000, 8'd15, 3'd2, 2'b01, 4'd14, 16, 2'b00);
        do_read(32'h5000, 8'd15, 3'd2, 2'b01, 4'd15, -1, lat);
        chk("wr_handshakes", wr_hs, 16);
        chk("rd_handshakes", rd_hs, 16);
        chk("scoreboard_empty", rq.size() + bq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
